sim_controller: RTL and testbench
=================================

// Module: sim_controller
// PURPOSE
//  Sits between user_interface and the life engine / board RAM. Turns the
//  speed switches into generation-step requests and the centre-button click
//  into a read-modify-write that toggles the cell under the cursor. It also
//  arbitrates so edits and generations never overlap on the board RAM.
// PARAMETERS
//  LOG_BOARD_SIZE  6   board is 2**LOG_BOARD_SIZE square; cursor width
//  LOG_MAX_SPEED   4   width of speed_in
//  LOG_TICK_BASE   22  tick accumulator width; step period = 2**LOG_TICK_BASE/speed cycles
// PORTS
//  clk_in           in   1               system clock
//  rst_n_in         in   1               async active-low reset
//  click_in         in   1               debounced centre button (level)
//  speed_in         in   LOG_MAX_SPEED   0 = paused, else rate multiplier
//  cursor_x_in      in   LOG_BOARD_SIZE  cursor column
//  cursor_y_in      in   LOG_BOARD_SIZE  cursor row
//  gen_ready_in     in   1               engine idle; drops after gen_step_out, rises when done
//  gen_step_out     out  1               1-cycle pulse: start one generation
//  edit_addr_out    out  2*LOG_BOARD_SIZE  {y,x} cell address
//  edit_rd_out      out  1               RAM read strobe; data valid 1 cycle later
//  edit_rd_data_in  in   1               cell value read
//  edit_wr_out      out  1               RAM write strobe
//  edit_wr_data_out out  1               value written (inverted read)
//  busy_out         out  1               FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, rst_n_in=0): all outputs 0; acc=0; step_pend=0; edit_pend=0;
//    click_q=1, so a button held through reset makes no edit; FSM=IDLE.
//  - Tick: each cycle acc <= acc + speed_in (LOG_TICK_BASE bits, wraps).
//    Carry-out sets step_pend. speed_in==0: acc holds, step_pend cleared.
//    Carries while step_pend is already set collapse (no queueing).
//  - Click: click_q <= click_in; rising edge (click_in & ~click_q) with
//    edit_pend=0 latches {cursor_y_in,cursor_x_in} into edit_addr and sets
//    edit_pend. Edges while edit_pend=1 are dropped.
//  - FSM states IDLE, STEP, RUN_LO, RUN_HI, RD, RD_WAIT, WR:
//    IDLE: if gen_ready_in & edit_pend -> RD (edit has priority);
//          else if gen_ready_in & step_pend -> STEP; else stay.
//    STEP: gen_step_out=1 for exactly this cycle; clear step_pend -> RUN_LO.
//    RUN_LO: wait for gen_ready_in=0 -> RUN_HI.
//    RUN_HI: wait for gen_ready_in=1 -> IDLE.
//    RD: edit_rd_out=1, edit_addr_out=latched addr -> RD_WAIT.
//    RD_WAIT: capture edit_rd_data_in -> WR.
//    WR: edit_wr_out=1, edit_wr_data_out=~captured, same addr; clear edit_pend -> IDLE.
//  - Edit latency: click edge -> edit_rd_out is 2 cycles (IDLE decision +
//    RD) when idle; WR lands 2 cycles after RD.
//  - edit_addr_out holds the latched address at all times; it is stable across RD..WR.
//  - Strobes gen_step_out/edit_rd_out/edit_wr_out are registered and mutually exclusive.
//  - Tick and click logic keep running in every state; requests wait for IDLE.
//  - Async reset mid-sequence aborts with no write issued after reset asserts.
// TESTING (LOG_TICK_BASE=4, LOG_BOARD_SIZE=3, engine model: ready drops 1 cycle
//  after step, rises 5 cycles later)
//  1 speed=4, no clicks -> gen_step_out pulses once every 4 cycles, single-cycle.
//  2 speed=1 -> carry every 16 cycles; speed=0 mid-count -> no further steps, acc frozen.
//  3 cursor=(x2,y5), click rise, RAM cell=0 -> rd addr 6'o52, wr addr 6'o52 data=1.
//  4 click during engine run -> RD only after gen_ready_in returns; step_pend and
//    edit_pend both set in IDLE -> edit runs first, step follows.
//  5 second click edge during RD_WAIT -> dropped; exactly one write.
//  6 click held high across rst_n_in pulse -> no edit; rst in RD_WAIT -> no edit_wr_out.

Source files
------------

// File: rtl/sim_controller.sv
// Speed/click front end for the life board: issues generation steps from a
// tick accumulator and turns cursor clicks into a read-invert-write of one cell.
module sim_controller #(
  parameter int unsigned LOG_BOARD_SIZE = 6,
  parameter int unsigned LOG_MAX_SPEED  = 4,
  parameter int unsigned LOG_TICK_BASE  = 22
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        click_in,
  input  logic [LOG_MAX_SPEED-1:0]    speed_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_y_in,
  input  logic                        gen_ready_in,
  output logic                        gen_step_out,
  output logic [2*LOG_BOARD_SIZE-1:0] edit_addr_out,
  output logic                        edit_rd_out,
  input  logic                        edit_rd_data_in,
  output logic                        edit_wr_out,
  output logic                        edit_wr_data_out,
  output logic                        busy_out
);

  localparam int unsigned ADDR_W = 2 * LOG_BOARD_SIZE;
  localparam int unsigned ACC_W  = LOG_TICK_BASE;
  localparam int unsigned SUM_W  = LOG_TICK_BASE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_RUN_LO,
    S_RUN_HI,
    S_RD,
    S_RD_WAIT,
    S_WR
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q;
  logic                step_pend_q;
  logic                edit_pend_q;
  logic                click_q;
  logic [ADDR_W-1:0]   edit_addr_q;
  logic                gen_step_q, edit_rd_q, edit_wr_q, wr_data_q, busy_q;

  logic [SUM_W-1:0]    acc_sum_c;
  logic                carry_c;
  logic                click_edge_c;
  logic                gen_step_d, edit_rd_d, edit_wr_d, wr_data_d, busy_d;

  assign acc_sum_c    = SUM_W'(acc_q) + SUM_W'(speed_in);
  assign carry_c      = acc_sum_c[SUM_W-1];
  assign click_edge_c = click_in & ~click_q;

  // Rate accumulator; a carry raises a step request, extra carries collapse into it
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q       <= '0;
      step_pend_q <= 1'b0;
    end else if (speed_in == '0) begin
      step_pend_q <= 1'b0;
    end else begin
      acc_q <= acc_sum_c[ACC_W-1:0];
      if (state_q == S_STEP) begin
        step_pend_q <= 1'b0;
      end else if (carry_c) begin
        step_pend_q <= 1'b1;
      end
    end
  end

  // click_q resets high so a button held through reset is not seen as a new press
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      click_q     <= 1'b1;
      edit_pend_q <= 1'b0;
      edit_addr_q <= '0;
    end else begin
      click_q <= click_in;
      if (state_q == S_WR) begin
        edit_pend_q <= 1'b0;
      end else if (click_edge_c && !edit_pend_q) begin
        edit_pend_q <= 1'b1;
        edit_addr_q <= {cursor_y_in, cursor_x_in};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      gen_step_q <= 1'b0;
      edit_rd_q  <= 1'b0;
      edit_wr_q  <= 1'b0;
      wr_data_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gen_step_q <= gen_step_d;
      edit_rd_q  <= edit_rd_d;
      edit_wr_q  <= edit_wr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  // Outputs are decoded from the next state so each strobe is high while its state is current
  always_comb begin
    state_d   = state_q;
    wr_data_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gen_ready_in && edit_pend_q) begin
          state_d = S_RD;
        end else if (gen_ready_in && step_pend_q) begin
          state_d = S_STEP;
        end
      end
      S_STEP:   state_d = S_RUN_LO;
      S_RUN_LO: if (!gen_ready_in) state_d = S_RUN_HI;
      S_RUN_HI: if (gen_ready_in) state_d = S_IDLE;
      S_RD:     state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        state_d   = S_WR;
        wr_data_d = ~edit_rd_data_in;
      end
      S_WR:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    gen_step_d = (state_d == S_STEP);
    edit_rd_d  = (state_d == S_RD);
    edit_wr_d  = (state_d == S_WR);
    busy_d     = (state_d != S_IDLE);
  end

  assign gen_step_out     = gen_step_q;
  assign edit_rd_out      = edit_rd_q;
  assign edit_wr_out      = edit_wr_q;
  assign edit_wr_data_out = wr_data_q;
  assign busy_out         = busy_q;
  assign edit_addr_out    = edit_addr_q;

endmodule

// File: tb/tb_sim_controller.sv
// Randomized and directed bench for sim_controller against a transaction-level
// reference model, with a small engine model and a board RAM.
module tb_sim_controller;

  localparam int unsigned LBS = 3;
  localparam int unsigned LMS = 4;
  localparam int unsigned LTB = 4;
  localparam int unsigned TICK_MOD = 16;
  localparam int unsigned CELLS = 64;

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic           click_in;
  logic [LMS-1:0] speed_in;
  logic [LBS-1:0] cursor_x_in, cursor_y_in;
  logic           gen_ready_in;
  logic           gen_step_out;
  logic [2*LBS-1:0] edit_addr_out;
  logic           edit_rd_out;
  logic           edit_rd_data_in;
  logic           edit_wr_out;
  logic           edit_wr_data_out;
  logic           busy_out;

  sim_controller #(.LOG_BOARD_SIZE(LBS), .LOG_MAX_SPEED(LMS), .LOG_TICK_BASE(LTB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .click_in(click_in), .speed_in(speed_in),
    .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in), .gen_ready_in(gen_ready_in),
    .gen_step_out(gen_step_out), .edit_addr_out(edit_addr_out), .edit_rd_out(edit_rd_out),
    .edit_rd_data_in(edit_rd_data_in), .edit_wr_out(edit_wr_out),
    .edit_wr_data_out(edit_wr_data_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Board RAM written by the DUT, and the model's idea of what it should hold
  bit ram[CELLS];
  bit shadow[CELLS];
  bit rd_prev;
  int eng_cnt;
  int eng_busy = 5;

  // Reference model: pending flags, counters, and the current operation with its age
  int       m_acc;
  bit       m_spend, m_epend, m_clickq, m_low, m_wv;
  int       m_op;   // 0 none, 1 generation, 2 cell edit
  int       m_age;
  bit [5:0] m_addr;

  function automatic bit m_in_wr();
    return (m_op == 2) && (m_age == 2);
  endfunction

  task automatic model_reset();
    // a write strobe cut short by reset never reaches the RAM
    if (m_in_wr()) shadow[m_addr] = !shadow[m_addr];
    m_acc = 0; m_spend = 0; m_epend = 0; m_clickq = 1;
    m_op = 0; m_age = 0; m_low = 0; m_addr = '0; m_wv = 0;
  endtask

  task automatic model_step();
    bit sp, ep, edge_seen, carry, in_step, in_wr;
    int sum;
    if (!rst_n_in) begin
      model_reset();
      return;
    end
    sp = m_spend;
    ep = m_epend;
    in_step = (m_op == 1) && (m_age == 0);
    in_wr = m_in_wr();
    sum = m_acc + int'(speed_in);
    carry = (sum >= TICK_MOD);
    if (speed_in == 0) m_spend = 0;
    else begin
      m_acc = sum % TICK_MOD;
      if (in_step) m_spend = 0;
      else if (carry) m_spend = 1;
    end
    edge_seen = click_in && !m_clickq;
    m_clickq = click_in;
    if (in_wr) m_epend = 0;
    else if (edge_seen && !ep) begin
      m_epend = 1;
      m_addr = {cursor_y_in, cursor_x_in};
    end
    if (m_op == 0) begin
      if (gen_ready_in && ep) begin m_op = 2; m_age = 0; end
      else if (gen_ready_in && sp) begin m_op = 1; m_age = 0; m_low = 0; end
    end else if (m_op == 1) begin
      if (m_age == 0) m_age = 1;
      else if (!m_low) begin if (!gen_ready_in) m_low = 1; end
      else if (gen_ready_in) m_op = 0;
    end else begin
      if (m_age == 2) m_op = 0;
      else begin
        m_age++;
        if (m_age == 2) begin
          m_wv = !shadow[m_addr];
          shadow[m_addr] = m_wv;
        end
      end
    end
  endtask

  // One clock: compare at negedge, respond as engine/RAM, then advance the model on posedge
  task automatic tick_cycle();
    bit exp_wr;
    @(negedge clk_in);
    exp_wr = m_in_wr();
    check("gen_step", gen_step_out, (m_op == 1 && m_age == 0));
    check("edit_rd", edit_rd_out, (m_op == 2 && m_age == 0));
    check("edit_wr", edit_wr_out, exp_wr);
    check("wr_data", edit_wr_data_out, exp_wr ? m_wv : 1'b0);
    check("busy", busy_out, (m_op != 0));
    check("addr", edit_addr_out, m_addr);
    if (!rst_n_in) begin
      gen_ready_in = 1'b1;
    end else if (gen_step_out) begin
      gen_ready_in = 1'b0;
      eng_cnt = eng_busy;
    end else if (!gen_ready_in) begin
      if (eng_cnt == 0) gen_ready_in = 1'b1;
      else eng_cnt--;
    end
    if (edit_wr_out) ram[edit_addr_out] = edit_wr_data_out;
    edit_rd_data_in = rd_prev ? ram[edit_addr_out] : 1'($urandom_range(0, 1));
    rd_prev = edit_rd_out;
    @(posedge clk_in);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic assert_reset();
    rst_n_in = 1'b0;
    model_reset();
    gen_ready_in = 1'b1;
    rd_prev = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    assert_reset();
    repeat (cycles) tick_cycle();
    rst_n_in = 1'b1;
  endtask

  int q_step[$];
  int n, n_rd, n_wr, n_step;
  int kinds[$];
  bit rd_early;

  initial begin
    rst_n_in = 1'b1; click_in = 1'b0; speed_in = '0;
    cursor_x_in = '0; cursor_y_in = '0; gen_ready_in = 1'b1; edit_rd_data_in = 1'b0;
    rd_prev = 1'b0; eng_cnt = 0;
    for (int i = 0; i < CELLS; i++) begin
      ram[i] = 1'($urandom_range(0, 1));
      shadow[i] = ram[i];
    end
    #1;
    apply_reset(2);
    check("rst_outs", {gen_step_out, edit_rd_out, edit_wr_out, edit_wr_data_out, busy_out}, 0);

    // speed 4 with a quick engine: one single-cycle step every 4 cycles
    eng_busy = 1; speed_in = 4'd4;
    q_step.delete();
    repeat (48) begin
      tick_cycle();
      if (gen_step_out) q_step.push_back(cyc);
    end
    check("t1_count_ok", (q_step.size() >= 10), 1);
    for (int i = 1; i < q_step.size(); i++) check("t1_gap", q_step[i] - q_step[i-1], 4);

    // speed 1: carry every 16 cycles, then pause and resume from the frozen count
    speed_in = 4'd0;
    apply_reset(2);
    speed_in = 4'd1;
    q_step.delete();
    repeat (40) begin
      tick_cycle();
      if (gen_step_out) q_step.push_back(cyc);
    end
    check("t2_count", q_step.size(), 2);
    if (q_step.size() >= 2) check("t2_gap", q_step[1] - q_step[0], 16);
    n = 0;
    while (!gen_step_out && n < 40) begin tick_cycle(); n++; end
    check("t2_found", gen_step_out, 1);
    repeat (2) tick_cycle();
    speed_in = 4'd0;
    n_step = 0;
    repeat (40) begin tick_cycle(); if (gen_step_out) n_step++; end
    check("t2_paused", n_step, 0);
    speed_in = 4'd1;
    n = 0;
    do begin tick_cycle(); n++; end while (!gen_step_out && n < 40);
    check("t2_resume", n, 14);

    // click at (x2,y5) on a clear cell; a second edge during RD_WAIT is dropped
    speed_in = 4'd0;
    apply_reset(2);
    eng_busy = 5;
    ram[6'o52] = 1'b0; shadow[6'o52] = 1'b0;
    cursor_x_in = 3'd2; cursor_y_in = 3'd5;
    tick_cycle();
    click_in = 1'b1;
    n = 0;
    do begin tick_cycle(); n++; end while (!edit_rd_out && n < 20);
    check("t3_latency", n, 2);
    check("t3_rd_addr", edit_addr_out, 6'o52);
    click_in = 1'b0;
    tick_cycle();
    click_in = 1'b1; cursor_x_in = 3'd7; cursor_y_in = 3'd1;
    tick_cycle();
    check("t3_wr", edit_wr_out, 1);
    check("t3_wr_addr", edit_addr_out, 6'o52);
    check("t3_wr_data", edit_wr_data_out, 1);
    n_rd = 0; n_wr = 0;
    repeat (12) begin tick_cycle(); n_rd += int'(edit_rd_out); n_wr += int'(edit_wr_out); end
    check("t5_extra_rd", n_rd, 0);
    check("t5_extra_wr", n_wr, 0);
    check("t3_ram", ram[6'o52], 1);

    // click while the engine runs: edit waits for ready, then runs ahead of the pending step
    click_in = 1'b0; speed_in = 4'd8;
    apply_reset(2);
    n = 0;
    while (!gen_step_out && n < 40) begin tick_cycle(); n++; end
    check("t4_step_seen", gen_step_out, 1);
    cursor_x_in = 3'd3; cursor_y_in = 3'd6;
    click_in = 1'b1;
    kinds.delete();
    rd_early = 0;
    repeat (30) begin
      tick_cycle();
      if (edit_rd_out && kinds.size() == 0 && !gen_ready_in) rd_early = 1;
      if (gen_step_out) kinds.push_back(1);
      if (edit_rd_out) kinds.push_back(2);
      if (edit_wr_out) kinds.push_back(3);
    end
    check("t4_rd_early", rd_early, 0);
    check("t4_n_events", (kinds.size() >= 3), 1);
    if (kinds.size() >= 3) begin
      check("t4_first", kinds[0], 2);
      check("t4_second", kinds[1], 3);
      check("t4_third", kinds[2], 1);
    end

    // click held through reset makes no edit; reset during RD_WAIT issues no write
    speed_in = 4'd0; click_in = 1'b0;
    tick_cycle();
    assert_reset();
    click_in = 1'b1;
    repeat (2) tick_cycle();
    rst_n_in = 1'b1;
    n_rd = 0;
    repeat (10) begin tick_cycle(); n_rd += int'(edit_rd_out); end
    check("t6_held_click", n_rd, 0);
    click_in = 1'b0;
    tick_cycle();
    click_in = 1'b1;
    n = 0;
    do begin tick_cycle(); n++; end while (!edit_rd_out && n < 20);
    check("t6_rd_seen", edit_rd_out, 1);
    tick_cycle();
    assert_reset();
    n_wr = 0;
    repeat (2) begin tick_cycle(); n_wr += int'(edit_wr_out); end
    rst_n_in = 1'b1;
    repeat (8) begin tick_cycle(); n_wr += int'(edit_wr_out); end
    check("t6_no_wr", n_wr, 0);

    // randomized traffic, every cycle checked against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0)
        speed_in = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) click_in = ~click_in;
      cursor_x_in = 3'($urandom);
      cursor_y_in = 3'($urandom);
      eng_busy = $urandom_range(1, 5);
      if ($urandom_range(0, 699) == 0) apply_reset($urandom_range(1, 2));
      else tick_cycle();
    end

    // idle out any in-flight edit, then the board must match the model
    speed_in = 4'd0; click_in = 1'b0;
    repeat (20) tick_cycle();
    for (int i = 0; i < CELLS; i++) check("ram_cell", ram[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
